// File: rtl/led_seq_pkg.sv
// Shared types and default sizing for the LED frame sequencer slice.
// Imported by the frame store and the sequencer control.
package led_seq_pkg;

  localparam int DEF_LED_W      = 10;
  localparam int DEF_NUM_FRAMES = 8;
  localparam int DEF_DWELL_W    = 18;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Index width for a frame store of the given depth; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/led_frame_ram.sv
// Frame store: one synchronous write port, one synchronous read port.
// The read register doubles as the LED drive register.
module led_frame_ram
  import led_seq_pkg::*;
#(
  parameter int LED_W      = DEF_LED_W,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int IDX_W      = idx_width(NUM_FRAMES)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [LED_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [LED_W-1:0] rd_data
);

  logic [LED_W-1:0] mem [NUM_FRAMES];

  // Contents are deliberately not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < NUM_FRAMES)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read samples the old contents when a write hits the same index.
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Plays a stored sequence of LED frames, holding each for a programmable dwell.
// Supports looping or one-shot playback with a done pulse, and an abort input.
module led_frame_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_W      = DEF_LED_W,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int DWELL_W    = DEF_DWELL_W,
  localparam int IDX_W     = idx_width(NUM_FRAMES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [LED_W-1:0]   wr_data,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [IDX_W-1:0]   last_idx,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   frame_idx,
  output logic [LED_W-1:0]   led,
  output state_t             state
);

  state_t             state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [IDX_W-1:0]   last_q, last_n;
  logic               loop_q, loop_n;
  logic               done_n;
  logic               rd_en, clr_n, rd_clr, wr_ok;
  logic [IDX_W-1:0]   rd_addr;
  logic [IDX_W-1:0]   last_clamped;

  always_comb begin
    last_clamped = last_idx;
    if (32'(last_idx) >= NUM_FRAMES) begin
      last_clamped = IDX_W'(NUM_FRAMES - 1);
    end
  end

  // The frame register is loaded only when a frame starts, so writes to the
  // displayed index never disturb the current dwell.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    dwell_n = dwell_q;
    last_n  = last_q;
    loop_n  = loop_q;
    done_n  = 1'b0;
    rd_en   = 1'b0;
    clr_n   = 1'b0;
    rd_addr = idx;
    case (state)
      IDLE: begin
        clr_n = 1'b1;
        if (start && !stop) begin
          state_n = PLAY;
          cnt_n   = '0;
          idx_n   = '0;
          dwell_n = dwell;
          last_n  = last_clamped;
          loop_n  = loop;
          clr_n   = 1'b0;
          rd_en   = 1'b1;
          rd_addr = '0;
        end
      end
      PLAY: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
          clr_n   = 1'b1;
        end else if (cnt == dwell_q) begin
          cnt_n = '0;
          if (idx < last_q) begin
            idx_n   = idx + 1'b1;
            rd_en   = 1'b1;
            rd_addr = idx_n;
          end else if (loop_q) begin
            idx_n   = '0;
            rd_en   = 1'b1;
            rd_addr = '0;
          end else begin
            state_n = IDLE;
            idx_n   = '0;
            clr_n   = 1'b1;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      dwell_q <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      dwell_q <= dwell_n;
      last_q  <= last_n;
      loop_q  <= loop_n;
      done    <= done_n;
    end
  end

  assign busy      = (state == PLAY);
  assign frame_idx = idx;
  assign rd_clr    = rst | clr_n;
  assign wr_ok     = wr_en & ~rst;

  led_frame_ram #(
    .LED_W      (LED_W),
    .NUM_FRAMES (NUM_FRAMES),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_clr  (rd_clr),
    .rd_addr (rd_addr),
    .rd_data (led)
  );

endmodule
